multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle MIPS datapath. Sequences every instruction through fetch, decode, execute, memory and writeback. Drives the PC-update controls (`PcWrite`, `PcWriteCond`, `PcSource`) consumed by the PC register, plus all memory, IR, register-file and ALU selects. A `mem_ready` handshake lets slow memory stall any memory-access state.

## Interface

- No parameters. Encodings are fixed in the shared package.

Ports:

- clk  in  1  system clock, rising edge. **Already decided.**
- reset  in  1  asynchronous, active-high. **Already decided.**
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- PcWrite  out  1  unconditional PC load
- PcWriteCond  out  1  PC load qualified by ALU zero (branch)
- PcSource  out  2  00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump address
- IorD  out  1  memory address select: 0 PC, 1 ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  destination select: 0 rt, 1 rd
- MemtoReg  out  1  write-data select: 0 ALUOut, 1 MDR
- RegWrite  out  1  register-file write enable
- ALUSrcA  out  1  ALU input A: 0 PC, 1 register A
- ALUSrcB  out  2  ALU input B: 00 B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 use funct
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal  out  1  one-cycle pulse in DECODE when the opcode is unsupported

## Operation

- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB.
- Supported opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- IDLE
  - Entered asynchronously on reset; all outputs 0.
  - Advances to FETCH on the first clk edge after reset deasserts.
- FETCH
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PcSource=00.
  - IRWrite and PcWrite equal mem_ready.
  - Holds in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 to precompute the branch target.
  - Next state by opcode: lw/sw→MEMADR, R→RTYPE_EX, beq→BRANCH, j→JUMP, addi→ADDI_EX.
  - Any other opcode: illegal=1, next state FETCH, no architectural writes.
- MEMADR
  - Drives ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: lw→MEMRD, sw→MEMWR (opcode held stable by IR).
- MEMRD
  - Drives MemRead=1, IorD=1.
  - Holds until mem_ready, then goes to MEMWB.
- MEMWB
  - Drives RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1.
  - Next state FETCH.
- MEMWR
  - Drives MemWrite=1, IorD=1.
  - Holds until mem_ready; instr_done=mem_ready; then goes to FETCH.
- RTYPE_EX
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next state RTYPE_WB.
- RTYPE_WB
  - Drives RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1.
  - Next state FETCH.
- BRANCH
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=01, PcWriteCond=1, PcSource=01, instr_done=1.
  - Next state FETCH.
- JUMP
  - Drives PcWrite=1, PcSource=10, instr_done=1.
  - Next state FETCH.
- ADDI_EX
  - Drives ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state ADDI_WB.
- ADDI_WB
  - Drives RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1.
  - Next state FETCH.
- Any output not listed for a state is 0, including the multi-bit selects.

## Timing

- Output type:
  - Outputs are Moore decodes of the state register.
  - Exceptions: FETCH IRWrite/PcWrite and MEMWR instr_done are combinational on mem_ready (Mealy).
  - No output is registered separately.
- Latency with mem_ready tied high, FETCH through the final state inclusive:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Exactly one of PcWrite and PcWriteCond is asserted in any cycle, or neither.
- MemRead and MemWrite are never both asserted.
- Reset mid-instruction: the state goes to IDLE immediately and all outputs drop to 0 asynchronously. No partial write may complete after reset asserts.
- Unreachable state encodings recover to FETCH on the next edge, with all outputs 0 while in them.

## Structure

- Package `mc_pkg` holds:
  - state enum
  - opcode constants
  - ALUOp, PcSource and ALUSrcB localparams
- Sub-module `mc_outdec`: a purely combinational map from (state, mem_ready) to the output vector.
- The top level holds only the state register and next-state logic.

## Test plan

- Reset:
  - Assert reset mid-MEMWR → outputs 0 the same cycle, including MemWrite.
  - Release reset → IDLE for one cycle, then FETCH.
- lw with mem_ready=1:
  - State sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB.
  - RegWrite=1 and MemtoReg=1 only in cycle 5; instr_done pulses once.
- Fetch stall: mem_ready=0 for 3 cycles in FETCH → FETCH held 4 cycles, IRWrite and PcWrite high only in the final cycle.
- beq:
  - BRANCH drives PcWriteCond=1, PcSource=01, ALUOp=01, PcWrite=0.
  - j drives PcWrite=1, PcSource=10.
- Illegal opcode 111111 → illegal pulses in DECODE, next state FETCH, no RegWrite or MemWrite.
- Back-to-back R-type then addi:
  - instr_done pulses at cycles 4 and 8.
  - RegDst=1 then RegDst=0 in the respective writeback cycles.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM.
package mc_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEMADR   = 4'd3,
      MEMRD    = 4'd4,
      MEMWB    = 4'd5,
      MEMWR    = 4'd6,
      RTYPE_EX = 4'd7,
      RTYPE_WB = 4'd8,
      BRANCH   = 4'd9,
      JUMP     = 4'd10,
      ADDI_EX  = 4'd11,
      ADDI_WB  = 4'd12
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       instr_done;
      logic       illegal;
   } ctrl_t;

   function automatic logic op_supported(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational output decode of the control FSM state. Everything is a
// Moore decode except the FETCH load strobes and the MEMWR done pulse,
// which follow mem_ready so a stalled access never commits early.
module mc_outdec
   import mc_pkg::*;
(
   input  state_t      state,
   input  logic        mem_ready,
   input  logic [5:0]  opcode,
   output ctrl_t       ctrl
);

   // Per-state control decode; unlisted fields and unknown encodings stay 0.
   always_comb begin
      ctrl = '0;
      case (state)
         IDLE: ;
         FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_source = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH2;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.illegal   = !op_supported(opcode);
         end
         MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         MEMWR: begin
            ctrl.mem_write  = 1'b1;
            ctrl.iord       = 1'b1;
            ctrl.instr_done = mem_ready;
         end
         RTYPE_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         RTYPE_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_B;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
            ctrl.instr_done    = 1'b1;
         end
         JUMP: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PCSRC_JUMP;
            ctrl.instr_done = 1'b1;
         end
         ADDI_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         ADDI_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath.
//
// state    | meaning
// IDLE     | held in reset; one cycle after release
// FETCH    | read instruction at PC, PC <= PC+4 when memory completes
// DECODE   | register read, branch target precomputed into ALUOut
// MEMADR   | effective address for lw/sw
// MEMRD    | data read for lw, waits on mem_ready
// MEMWB    | lw writeback from MDR to rt
// MEMWR    | data write for sw, waits on mem_ready
// RTYPE_EX | ALU operation selected by funct
// RTYPE_WB | R-type writeback to rd
// BRANCH   | beq compare, PC <= ALUOut if zero
// JUMP     | PC <= jump address
// ADDI_EX  | register plus sign-extended immediate
// ADDI_WB  | addi writeback to rt
module multicycle_control
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PcWrite,
   output logic       PcWriteCond,
   output logic [1:0] PcSource,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       instr_done,
   output logic       illegal
);

   state_t state_q;
   state_t state_d;
   ctrl_t  ctrl;

   // State register; reset forces IDLE at once so outputs drop without a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; unknown encodings fall back to FETCH.
   always_comb begin
      state_d = FETCH;
      case (state_q)
         IDLE:   state_d = FETCH;
         FETCH:  state_d = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = RTYPE_EX;
               OP_BEQ:       state_d = BRANCH;
               OP_J:         state_d = JUMP;
               OP_ADDI:      state_d = ADDI_EX;
               default:      state_d = FETCH;
            endcase
         end
         MEMADR: begin
            if (opcode == OP_LW)      state_d = MEMRD;
            else if (opcode == OP_SW) state_d = MEMWR;
            else                      state_d = FETCH;
         end
         MEMRD:    state_d = mem_ready ? MEMWB : MEMRD;
         MEMWB:    state_d = FETCH;
         MEMWR:    state_d = mem_ready ? FETCH : MEMWR;
         RTYPE_EX: state_d = RTYPE_WB;
         RTYPE_WB: state_d = FETCH;
         BRANCH:   state_d = FETCH;
         JUMP:     state_d = FETCH;
         ADDI_EX:  state_d = ADDI_WB;
         ADDI_WB:  state_d = FETCH;
         default:  state_d = FETCH;
      endcase
   end

   mc_outdec u_outdec (
      .state     (state_q),
      .mem_ready (mem_ready),
      .opcode    (opcode),
      .ctrl      (ctrl)
   );

   assign PcWrite     = ctrl.pc_write;
   assign PcWriteCond = ctrl.pc_write_cond;
   assign PcSource    = ctrl.pc_source;
   assign IorD        = ctrl.iord;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign IRWrite     = ctrl.ir_write;
   assign RegDst      = ctrl.reg_dst;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign RegWrite    = ctrl.reg_write;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign ALUOp       = ctrl.alu_op;
   assign instr_done  = ctrl.instr_done;
   assign illegal     = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for the multicycle control FSM. Inputs change 1 ns after
// the rising edge, outputs are sampled 4 ns after it.
module tb_multicycle_control;
   import mc_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       RegDst, MemtoReg, RegWrite, ALUSrcA, instr_done, illegal;
   logic [1:0] PcSource, ALUSrcB, ALUOp;
   logic [17:0] outs;

   int checks = 0;
   int errors = 0;

   // field order: PcWrite PcWriteCond PcSource IorD MemRead MemWrite IRWrite
   //              RegDst MemtoReg RegWrite ALUSrcA ALUSrcB ALUOp instr_done illegal
   localparam logic [17:0] E_ZERO    = 18'b0;
   localparam logic [17:0] E_FETCH_W = 18'b0_0_00_0_1_0_0_0_0_0_0_01_00_0_0;
   localparam logic [17:0] E_FETCH_R = 18'b1_0_00_0_1_0_1_0_0_0_0_01_00_0_0;
   localparam logic [17:0] E_DECODE  = 18'b0_0_00_0_0_0_0_0_0_0_0_11_00_0_0;
   localparam logic [17:0] E_DEC_ILL = 18'b0_0_00_0_0_0_0_0_0_0_0_11_00_0_1;
   localparam logic [17:0] E_MEMADR  = 18'b0_0_00_0_0_0_0_0_0_0_1_10_00_0_0;
   localparam logic [17:0] E_MEMRD   = 18'b0_0_00_1_1_0_0_0_0_0_0_00_00_0_0;
   localparam logic [17:0] E_MEMWB   = 18'b0_0_00_0_0_0_0_0_1_1_0_00_00_1_0;
   localparam logic [17:0] E_MEMWR_W = 18'b0_0_00_1_0_1_0_0_0_0_0_00_00_0_0;
   localparam logic [17:0] E_MEMWR_R = 18'b0_0_00_1_0_1_0_0_0_0_0_00_00_1_0;
   localparam logic [17:0] E_REX     = 18'b0_0_00_0_0_0_0_0_0_0_1_00_10_0_0;
   localparam logic [17:0] E_RWB     = 18'b0_0_00_0_0_0_0_1_0_1_0_00_00_1_0;
   localparam logic [17:0] E_BRANCH  = 18'b0_1_01_0_0_0_0_0_0_0_1_00_01_1_0;
   localparam logic [17:0] E_JUMP    = 18'b1_0_10_0_0_0_0_0_0_0_0_00_00_1_0;
   localparam logic [17:0] E_AEX     = 18'b0_0_00_0_0_0_0_0_0_0_1_10_00_0_0;
   localparam logic [17:0] E_AWB     = 18'b0_0_00_0_0_0_0_0_0_1_0_00_00_1_0;

   assign outs = {PcWrite, PcWriteCond, PcSource, IorD, MemRead, MemWrite, IRWrite,
                  RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal};

   multicycle_control dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .mem_ready   (mem_ready),
      .PcWrite     (PcWrite),
      .PcWriteCond (PcWriteCond),
      .PcSource    (PcSource),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .RegDst      (RegDst),
      .MemtoReg    (MemtoReg),
      .RegWrite    (RegWrite),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .instr_done  (instr_done),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; opcode = OP_RTYPE; mem_ready = 1'b0;
      #3;
      checks++;
      if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
      checks++;
      if (outs !== E_ZERO) begin errors++; $display("FAIL reset_outs: got %b expected %b", outs, E_ZERO); end
      cyc();
      reset = 1'b0;
      #3;
      checks++;
      if (dut.state_q !== IDLE) begin errors++; $display("FAIL release_idle: got %0d expected %0d", dut.state_q, IDLE); end
      checks++;
      if (outs !== E_ZERO) begin errors++; $display("FAIL release_outs: got %b expected %b", outs, E_ZERO); end
      cyc();
      #3;
      checks++;
      if (dut.state_q !== FETCH) begin errors++; $display("FAIL release_fetch: got %0d expected %0d", dut.state_q, FETCH); end
      checks++;
      if (outs !== E_FETCH_W) begin errors++; $display("FAIL release_fetch_outs: got %b expected %b", outs, E_FETCH_W); end
      cyc();
   endtask

   task automatic test_lw();
      state_t      es[6] = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH};
      logic [17:0] eo[6] = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH_W};
      bit          rd[6] = '{1, 1, 1, 1, 1, 0};
      opcode = OP_LW;
      for (int i = 0; i < 6; i++) begin
         mem_ready = rd[i];
         #3;
         checks++;
         if (dut.state_q !== es[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, dut.state_q, es[i]); end
         checks++;
         if (outs !== eo[i]) begin errors++; $display("FAIL lw_outs[%0d]: got %b expected %b", i, outs, eo[i]); end
         cyc();
      end
   endtask

   task automatic test_fetch_stall_jump();
      state_t      es[7] = '{FETCH, FETCH, FETCH, FETCH, DECODE, JUMP, FETCH};
      logic [17:0] eo[7] = '{E_FETCH_W, E_FETCH_W, E_FETCH_W, E_FETCH_R, E_DECODE, E_JUMP, E_FETCH_W};
      bit          rd[7] = '{0, 0, 0, 1, 1, 1, 0};
      opcode = OP_J;
      for (int i = 0; i < 7; i++) begin
         mem_ready = rd[i];
         #3;
         checks++;
         if (dut.state_q !== es[i]) begin errors++; $display("FAIL stall_j_state[%0d]: got %0d expected %0d", i, dut.state_q, es[i]); end
         checks++;
         if (outs !== eo[i]) begin errors++; $display("FAIL stall_j_outs[%0d]: got %b expected %b", i, outs, eo[i]); end
         cyc();
      end
   endtask

   task automatic test_beq();
      state_t      es[4] = '{FETCH, DECODE, BRANCH, FETCH};
      logic [17:0] eo[4] = '{E_FETCH_R, E_DECODE, E_BRANCH, E_FETCH_W};
      bit          rd[4] = '{1, 1, 1, 0};
      opcode = OP_BEQ;
      for (int i = 0; i < 4; i++) begin
         mem_ready = rd[i];
         #3;
         checks++;
         if (dut.state_q !== es[i]) begin errors++; $display("FAIL beq_state[%0d]: got %0d expected %0d", i, dut.state_q, es[i]); end
         checks++;
         if (outs !== eo[i]) begin errors++; $display("FAIL beq_outs[%0d]: got %b expected %b", i, outs, eo[i]); end
         cyc();
      end
   endtask

   task automatic test_illegal();
      state_t      es[3] = '{FETCH, DECODE, FETCH};
      logic [17:0] eo[3] = '{E_FETCH_R, E_DEC_ILL, E_FETCH_W};
      bit          rd[3] = '{1, 1, 0};
      opcode = 6'b111111;
      for (int i = 0; i < 3; i++) begin
         mem_ready = rd[i];
         #3;
         checks++;
         if (dut.state_q !== es[i]) begin errors++; $display("FAIL illegal_state[%0d]: got %0d expected %0d", i, dut.state_q, es[i]); end
         checks++;
         if (outs !== eo[i]) begin errors++; $display("FAIL illegal_outs[%0d]: got %b expected %b", i, outs, eo[i]); end
         cyc();
      end
   endtask

   task automatic test_sw_stall();
      state_t      es[6] = '{FETCH, DECODE, MEMADR, MEMWR, MEMWR, FETCH};
      logic [17:0] eo[6] = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMWR_W, E_MEMWR_R, E_FETCH_W};
      bit          rd[6] = '{1, 1, 1, 0, 1, 0};
      opcode = OP_SW;
      for (int i = 0; i < 6; i++) begin
         mem_ready = rd[i];
         #3;
         checks++;
         if (dut.state_q !== es[i]) begin errors++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, dut.state_q, es[i]); end
         checks++;
         if (outs !== eo[i]) begin errors++; $display("FAIL sw_outs[%0d]: got %b expected %b", i, outs, eo[i]); end
         cyc();
      end
   endtask

   task automatic test_back_to_back();
      state_t      es[9] = '{FETCH, DECODE, RTYPE_EX, RTYPE_WB, FETCH, DECODE, ADDI_EX, ADDI_WB, FETCH};
      logic [17:0] eo[9] = '{E_FETCH_R, E_DECODE, E_REX, E_RWB, E_FETCH_R, E_DECODE, E_AEX, E_AWB, E_FETCH_W};
      bit          rd[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
      for (int i = 0; i < 9; i++) begin
         opcode    = (i < 4) ? OP_RTYPE : OP_ADDI;
         mem_ready = rd[i];
         #3;
         checks++;
         if (dut.state_q !== es[i]) begin errors++; $display("FAIL b2b_state[%0d]: got %0d expected %0d", i, dut.state_q, es[i]); end
         checks++;
         if (outs !== eo[i]) begin errors++; $display("FAIL b2b_outs[%0d]: got %b expected %b", i, outs, eo[i]); end
         cyc();
      end
   endtask

   task automatic test_reset_mid_write();
      opcode = OP_SW; mem_ready = 1'b1;
      cyc(); cyc(); cyc();
      mem_ready = 1'b0;
      #3;
      checks++;
      if (outs !== E_MEMWR_W) begin errors++; $display("FAIL midrst_pre_outs: got %b expected %b", outs, E_MEMWR_W); end
      reset = 1'b1;
      #1;
      checks++;
      if (outs !== E_ZERO) begin errors++; $display("FAIL midrst_outs: got %b expected %b", outs, E_ZERO); end
      checks++;
      if (MemWrite !== 1'b0) begin errors++; $display("FAIL midrst_memwrite: got %b expected 0", MemWrite); end
      checks++;
      if (dut.state_q !== IDLE) begin errors++; $display("FAIL midrst_state: got %0d expected %0d", dut.state_q, IDLE); end
      cyc();
      reset = 1'b0;
      #3;
      checks++;
      if (dut.state_q !== IDLE) begin errors++; $display("FAIL midrst_idle: got %0d expected %0d", dut.state_q, IDLE); end
      cyc();
      #3;
      checks++;
      if (dut.state_q !== FETCH) begin errors++; $display("FAIL midrst_fetch: got %0d expected %0d", dut.state_q, FETCH); end
      checks++;
      if (outs !== E_FETCH_W) begin errors++; $display("FAIL midrst_fetch_outs: got %b expected %b", outs, E_FETCH_W); end
      cyc();
   endtask

   initial begin
      test_reset();
      test_lw();
      test_fetch_stall_jump();
      test_beq();
      test_illegal();
      test_sw_stall();
      test_back_to_back();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded 100000 ns");
      $fatal(1);
   end

endmodule
